// File: rtl/audio_pkg.sv
// Shared types for the speaker-side audio scheduler.
// Holds the default word width, FSM state encoding and stereo pair bundle.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_e;

  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } pair_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of stereo pairs between the producer and the scheduler.
// Pointers carry one wrap bit so full and empty fall out of their difference.
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter int W     = 2 * AUDIO_SAMPLE_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [AW:0]  count;
  logic         do_push;
  logic         do_pop;

  // occupancy, flags and next pointers
  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    rd_data = mem_q[rptr_q[AW-1:0]];
  end

  // pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_tx_scheduler.sv
// Speaker serializer sequencer: pair FIFO, bit divider, L/R slot FSM.
// Build option UNDERRUN_MUTE_EN: send silence on underrun instead of repeating.
module audio_tx_scheduler
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                bit_tick,
  output logic                ser_load,
  output logic [SAMPLE_W-1:0] ser_word,
  output logic                lrclk,
  output logic                busy,
  output logic                underrun,
  output logic [7:0]          urun_cnt
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(SAMPLE_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLE_W - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                ser_load_q, ser_load_d;
  logic [SAMPLE_W-1:0] ser_word_q, ser_word_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                lrclk_q, lrclk_d;
  logic                urun_q, urun_d;
  logic [7:0]          urun_cnt_q, urun_cnt_d;
`ifndef UNDERRUN_MUTE_EN
  logic [SAMPLE_W-1:0] last_l_q, last_l_d;
`endif

  logic                  tick;
  logic                  last_bit;
  logic                  enter_left;
  logic                  enter_right;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [2*SAMPLE_W-1:0] fifo_rd;
  logic [SAMPLE_W-1:0]   rd_left;
  logic [SAMPLE_W-1:0]   rd_right;

  audio_pair_fifo #(
    .W     (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid && !fifo_full),
    .pop     (fifo_pop),
    .wr_data ({in_left, in_right}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_left  = fifo_rd[2*SAMPLE_W-1:SAMPLE_W];
  assign rd_right = fifo_rd[SAMPLE_W-1:0];

  assign in_ready = !fifo_full;
  assign bit_tick = tick;
  assign ser_load = ser_load_q;
  assign ser_word = ser_word_q;
  assign lrclk    = lrclk_q;
  assign busy     = (state_q != IDLE);
  assign underrun = urun_q;
  assign urun_cnt = urun_cnt_q;

  // divider, bit index and slot sequencing
  always_comb begin
    tick        = (state_q != IDLE) && (cnt_q == CNT_LAST);
    last_bit    = (bit_q == BIT_LAST);
    state_d     = state_q;
    cnt_d       = '0;
    bit_d       = bit_q;
    enter_left  = 1'b0;
    enter_right = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        if (enable) state_d = START;
      end
      START: begin
        if (tick) enter_left = 1'b1;
      end
      LEFT: begin
        if (tick) begin
          if (last_bit) enter_right = 1'b1;
          else bit_d = bit_q + BW'(1);
        end
      end
      RIGHT: begin
        if (tick) begin
          if (!last_bit) bit_d = bit_q + BW'(1);
          else if (enable) enter_left = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_left) begin
      state_d = LEFT;
      bit_d   = '0;
    end
    if (enter_right) begin
      state_d = RIGHT;
      bit_d   = '0;
    end
  end

  // slot word selection, FIFO pop and underrun bookkeeping
  always_comb begin
    ser_load_d = 1'b0;
    ser_word_d = ser_word_q;
    hold_d     = hold_q;
    lrclk_d    = lrclk_q;
    urun_d     = urun_q;
    urun_cnt_d = urun_cnt_q;
    fifo_pop   = 1'b0;
`ifndef UNDERRUN_MUTE_EN
    last_l_d   = last_l_q;
`endif
    unique case (1'b1)
      enter_left: begin
        ser_load_d = 1'b1;
        lrclk_d    = 1'b0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          ser_word_d = rd_left;
          hold_d     = rd_right;
`ifndef UNDERRUN_MUTE_EN
          last_l_d   = rd_left;
`endif
        end else begin
          urun_d     = 1'b1;
          urun_cnt_d = sat_inc8(urun_cnt_q);
`ifdef UNDERRUN_MUTE_EN
          ser_word_d = '0;
          hold_d     = '0;
`else
          ser_word_d = last_l_q;
          hold_d     = hold_q;
`endif
        end
      end
      enter_right: begin
        ser_load_d = 1'b1;
        lrclk_d    = 1'b1;
        ser_word_d = hold_q;
      end
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ser_load_q <= 1'b0;
      ser_word_q <= '0;
      hold_q     <= '0;
      lrclk_q    <= 1'b0;
      urun_q     <= 1'b0;
      urun_cnt_q <= '0;
`ifndef UNDERRUN_MUTE_EN
      last_l_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ser_load_q <= ser_load_d;
      ser_word_q <= ser_word_d;
      hold_q     <= hold_d;
      lrclk_q    <= lrclk_d;
      urun_q     <= urun_d;
      urun_cnt_q <= urun_cnt_d;
`ifndef UNDERRUN_MUTE_EN
      last_l_q   <= last_l_d;
`endif
    end
  end

endmodule

// File: tb/tb_audio_tx_scheduler.sv
// Scoreboard bench for audio_tx_scheduler (CLK_DIV=8, depth 4).
// Expected slot words are queued at stimulus time and popped on ser_load.
module tb_audio_tx_scheduler;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        bit_tick;
  logic        ser_load;
  logic [15:0] ser_word;
  logic        lrclk;
  logic        busy;
  logic        underrun;
  logic [7:0]  urun_cnt;

  typedef struct {
    logic [15:0] w;
    logic        lr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  audio_tx_scheduler #(
    .SAMPLE_W   (16),
    .CLK_DIV    (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_left  (in_left),
    .in_right (in_right),
    .bit_tick (bit_tick),
    .ser_load (ser_load),
    .ser_word (ser_word),
    .lrclk    (lrclk),
    .busy     (busy),
    .underrun (underrun),
    .urun_cnt (urun_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t pop_exp();
    exp_t e;
    e.w  = 16'hxxxx;
    e.lr = 1'bx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic expect_pair(input pair_t p);
    exp_q.push_back('{p.left, 1'b0});
    exp_q.push_back('{p.right, 1'b1});
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_pair(input pair_t p, output bit ok);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_left  = p.left;
    in_right = p.right;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) expect_pair(p);
  endtask

  task automatic wait_load(output int cyc, output int tk, output bit ok);
    cyc = 0;
    tk  = 0;
    ok  = 1'b0;
    while (!ok && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bit_tick) tk++;
      if (ser_load) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output int cyc, output int tk, output bit ok);
    cyc = 0;
    tk  = 0;
    ok  = 1'b0;
    while (!ok && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bit_tick) tk++;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_in_ready: got %b need 1", in_ready);
    end
    vectors++;
    if ({bit_tick, ser_load, lrclk, busy, underrun} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_flags: got tick/load/lr/busy/urun=%b need 00000",
               {bit_tick, ser_load, lrclk, busy, underrun});
    end
    vectors++;
    if (ser_word !== 16'h0 || urun_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL rst_words: got word=%h cnt=%0d need 0/0", ser_word, urun_cnt);
    end
  endtask

  task automatic test_basic();
    bit   ok;
    int   cyc, tk;
    exp_t e;
    do_reset();
    push_pair('{16'h1234, 16'hABCD}, ok);
    enable = 1'b1;
    wait_load(cyc, tk, ok);
    vectors++;
    if (!ok || cyc !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got ok=%b cycles=%0d need 9", ok, cyc);
    end
    e = pop_exp();
    vectors++;
    if (ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL basic_left: got %h/%b need %h/%b", ser_word, lrclk, e.w, e.lr);
    end
    enable = 1'b0;
    wait_load(cyc, tk, ok);
    vectors++;
    if (!ok || cyc !== 128 || tk !== 16) begin
      miscompares++;
      $display("FAIL basic_gap: got ok=%b cycles=%0d ticks=%0d need 128/16", ok, cyc, tk);
    end
    e = pop_exp();
    vectors++;
    if (ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL basic_right: got %h/%b need %h/%b", ser_word, lrclk, e.w, e.lr);
    end
    wait_idle(cyc, tk, ok);
    vectors++;
    if (!ok || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got idle=%b urun=%b need 1/0", ok, underrun);
    end
  endtask

  task automatic test_fifo_full();
    pair_t pp[5];
    bit    ok, acc;
    int    cyc, tk;
    exp_t  e;
    for (int i = 0; i < 5; i++) begin
      pp[i] = '{16'h1000 + 16'(i), 16'h2000 + 16'(i)};
    end
    do_reset();
    acc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_pair(pp[i], ok);
      acc &= ok;
    end
    vectors++;
    if (!acc || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got accepted=%b in_ready=%b need 1/0", acc, in_ready);
    end
    in_valid = 1'b1;
    in_left  = pp[4].left;
    in_right = pp[4].right;
    enable   = 1'b1;
    cyc      = 0;
    while (!in_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 9 || ser_load !== 1'b1) begin
      miscompares++;
      $display("FAIL full_release: got cycles=%0d load=%b need 9/1", cyc, ser_load);
    end
    e = pop_exp();
    vectors++;
    if (ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL full_word0: got %h/%b need %h/%b", ser_word, lrclk, e.w, e.lr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    expect_pair(pp[4]);
    for (int i = 1; i < 10; i++) begin
      wait_load(cyc, tk, ok);
      if (i == 8) enable = 1'b0;
      e = pop_exp();
      vectors++;
      if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
        miscompares++;
        $display("FAIL full_word%0d: got ok=%b %h/%b need %h/%b",
                 i, ok, ser_word, lrclk, e.w, e.lr);
      end
    end
    wait_idle(cyc, tk, ok);
    vectors++;
    if (!ok || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle: got idle=%b urun=%b need 1/0", ok, underrun);
    end
  endtask

  task automatic test_underrun();
    bit   ok;
    int   cyc, tk;
    exp_t e;
    do_reset();
    expect_pair('{16'h0000, 16'h0000});
    enable = 1'b1;
    wait_load(cyc, tk, ok);
    e = pop_exp();
    vectors++;
    if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL urun_left: got ok=%b %h/%b need %h/%b", ok, ser_word, lrclk, e.w, e.lr);
    end
    vectors++;
    if (underrun !== 1'b1 || urun_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL urun_flag: got flag=%b cnt=%0d need 1/1", underrun, urun_cnt);
    end
    enable = 1'b0;
    wait_load(cyc, tk, ok);
    e = pop_exp();
    vectors++;
    if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL urun_right: got ok=%b %h/%b need %h/%b", ok, ser_word, lrclk, e.w, e.lr);
    end
    wait_idle(cyc, tk, ok);
  endtask

  task automatic test_starve();
    pair_t a;
    bit    ok;
    int    cyc, tk;
    exp_t  e;
    a = '{16'h5A5A, 16'h0F0F};
    do_reset();
    push_pair(a, ok);
`ifdef UNDERRUN_MUTE_EN
    expect_pair('{16'h0000, 16'h0000});
`else
    expect_pair(a);
`endif
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_load(cyc, tk, ok);
      if (i == 2) enable = 1'b0;
      e = pop_exp();
      vectors++;
      if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
        miscompares++;
        $display("FAIL starve_word%0d: got ok=%b %h/%b need %h/%b",
                 i, ok, ser_word, lrclk, e.w, e.lr);
      end
    end
    vectors++;
    if (underrun !== 1'b1 || urun_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL starve_flag: got flag=%b cnt=%0d need 1/1", underrun, urun_cnt);
    end
    wait_idle(cyc, tk, ok);
  endtask

  task automatic test_enable_drop();
    bit   ok;
    int   cyc, tk, c1;
    exp_t e;
    do_reset();
    push_pair('{16'hC3C3, 16'h3C3C}, ok);
    enable = 1'b1;
    wait_load(cyc, tk, ok);
    e = pop_exp();
    vectors++;
    if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL drop_left: got ok=%b %h/%b need %h/%b", ok, ser_word, lrclk, e.w, e.lr);
    end
    c1 = 0;
    tk = 0;
    while (tk < 3 && c1 < 2000) begin
      @(negedge clk);
      c1++;
      if (bit_tick) tk++;
    end
    enable = 1'b0;
    wait_load(cyc, tk, ok);
    e = pop_exp();
    vectors++;
    if (!ok || c1 + cyc !== 128 || ser_word !== e.w || lrclk !== e.lr) begin
      miscompares++;
      $display("FAIL drop_right: got gap=%0d %h/%b need 128 %h/%b",
               c1 + cyc, ser_word, lrclk, e.w, e.lr);
    end
    wait_idle(cyc, tk, ok);
    vectors++;
    if (!ok || cyc !== 128 || tk !== 16) begin
      miscompares++;
      $display("FAIL drop_idle: got ok=%b cycles=%0d ticks=%0d need 128/16", ok, cyc, tk);
    end
    tk = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bit_tick || ser_load || busy) tk++;
    end
    vectors++;
    if (tk !== 0) begin
      miscompares++;
      $display("FAIL drop_quiet: got %0d active cycles need 0", tk);
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   cyc, tk;
    exp_t e;
    do_reset();
    push_pair('{16'h1111, 16'h2222}, ok);
    push_pair('{16'h3333, 16'h4444}, ok);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_load(cyc, tk, ok);
      e = pop_exp();
      vectors++;
      if (!ok || ser_word !== e.w || lrclk !== e.lr) begin
        miscompares++;
        $display("FAIL rmid_word%0d: got ok=%b %h/%b need %h/%b",
                 i, ok, ser_word, lrclk, e.w, e.lr);
      end
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bit_tick, ser_load, lrclk, busy, underrun} !== 5'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_flags: got tick/load/lr/busy/urun=%b rdy=%b need 00000/1",
               {bit_tick, ser_load, lrclk, busy, underrun}, in_ready);
    end
    vectors++;
    if (ser_word !== 16'h0 || urun_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL rmid_words: got word=%h cnt=%0d need 0/0", ser_word, urun_cnt);
    end
    reset = 1'b0;
    exp_q.delete();
    expect_pair('{16'h0000, 16'h0000});
    wait_load(cyc, tk, ok);
    e = pop_exp();
    vectors++;
    if (!ok || ser_word !== e.w || underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_empty: got ok=%b word=%h urun=%b need %h/1", ok, ser_word, underrun, e.w);
    end
    enable = 1'b0;
    wait_load(cyc, tk, ok);
    wait_idle(cyc, tk, ok);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_underrun();
    test_starve();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
